// File: rtl/edge_event_arbiter_pkg.sv
// Shared types and the round-robin helper for the edge event arbiter.
package edge_evt_pkg;

  typedef enum logic [1:0] {
    EM_OFF  = 2'b00,
    EM_RISE = 2'b01,
    EM_FALL = 2'b10,
    EM_BOTH = 2'b11
  } edge_mode_e;

  localparam int unsigned RR_MAX_CH = 16;
  localparam int unsigned RR_IDX_W  = 4;

  // Unused upper channels are zero-padded, so a plain mod-16 walk keeps RR order.
  function automatic logic [RR_IDX_W-1:0] rr_pick(input logic [RR_MAX_CH-1:0] pending,
                                                 input logic [RR_IDX_W-1:0]  last);
    logic [RR_IDX_W-1:0] idx;
    logic                found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= RR_MAX_CH; i++) begin
      idx = last + RR_IDX_W'(i);
      if (!found && pending[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end else begin
        found   = found;
      end
    end
  endfunction

endpackage

// File: rtl/edge_event_arbiter_chan.sv
// One channel: edge detection, mode qualification, pending/type latch and
// sticky overflow flag.
module edge_evt_chan
  import edge_evt_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       a_i,
  input  edge_mode_e mode_i,
  input  logic       load_i,
  input  logic       clr_ovf_i,
  output logic       pending_o,
  output logic       ptype_o,
  output logic       overflow_o
);

  logic prev_q;
  logic pending_q, pending_d;
  logic ptype_q, ptype_d;
  logic overflow_q, overflow_d;
  logic rise_s, fall_s, qual_s;

  // Edge qualification and next-state for the pending/type/overflow flops
  always_comb begin
    rise_s     = a_i & ~prev_q;
    fall_s     = ~a_i & prev_q;
    pending_d  = pending_q;
    ptype_d    = ptype_q;
    overflow_d = overflow_q;

    case (mode_i)
      EM_OFF:  qual_s = 1'b0;
      EM_RISE: qual_s = rise_s;
      EM_FALL: qual_s = fall_s;
      EM_BOTH: qual_s = rise_s | fall_s;
      default: qual_s = 1'b0;
    endcase

    // A slot being freed this cycle can take the new edge; otherwise oldest wins.
    if (qual_s && (load_i || !pending_q)) begin
      pending_d = 1'b1;
      ptype_d   = rise_s;
    end else if (load_i) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end

    if (qual_s && pending_q && !load_i) begin
      overflow_d = 1'b1;
    end else if (clr_ovf_i) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // prev tracks the input even in reset so release never produces an edge
  always_ff @(posedge clk) begin
    prev_q <= a_i;
    if (reset) begin
      pending_q  <= 1'b0;
      ptype_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      ptype_q    <= ptype_d;
      overflow_q <= overflow_d;
    end
  end

  assign pending_o  = pending_q;
  assign ptype_o    = ptype_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Per-channel edge detectors feeding a round-robin serializer onto one
// registered valid/ready event port.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int ID_W  = $clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   a_i,
  input  logic [2*NUM_CH-1:0] mode_i,
  output logic                evt_valid_o,
  input  logic                evt_ready_i,
  output logic [ID_W-1:0]     evt_id_o,
  output logic                evt_rise_o,
  output logic [NUM_CH-1:0]   overflow_o,
  input  logic                clr_ovf_i
);

  logic [NUM_CH-1:0]   pend_s;
  logic [NUM_CH-1:0]   ptype_s;
  logic [NUM_CH-1:0]   load_s;
  logic                load_slot_s;
  logic                any_pend_s;
  logic [RR_IDX_W-1:0] pick_s;
  logic [ID_W-1:0]     winner_s;

  logic            valid_q, valid_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            rise_q, rise_d;
  logic [ID_W-1:0] last_q, last_d;

  assign load_slot_s = !valid_q || evt_ready_i;
  assign any_pend_s  = |pend_s;
  assign pick_s      = rr_pick(RR_MAX_CH'(pend_s), RR_IDX_W'(last_q));
  assign winner_s    = ID_W'(pick_s);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    localparam logic [ID_W-1:0] CID = ID_W'(c);

    assign load_s[c] = load_slot_s && any_pend_s && (winner_s == CID);

    edge_evt_chan u_chan (
      .clk        (clk),
      .reset      (reset),
      .a_i        (a_i[c]),
      .mode_i     (edge_mode_e'(mode_i[2*c +: 2])),
      .load_i     (load_s[c]),
      .clr_ovf_i  (clr_ovf_i),
      .pending_o  (pend_s[c]),
      .ptype_o    (ptype_s[c]),
      .overflow_o (overflow_o[c])
    );
  end

  // Output register next state: load the RR winner in a load slot, else hold
  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    rise_d  = rise_q;
    last_d  = last_q;
    if (load_slot_s) begin
      if (any_pend_s) begin
        valid_d = 1'b1;
        id_d    = winner_s;
        rise_d  = ptype_s[winner_s];
        last_d  = winner_s;
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Output and round-robin pointer registers; pointer resets so channel 0 goes first
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      id_q    <= '0;
      rise_q  <= 1'b0;
      last_q  <= ID_W'(NUM_CH - 1);
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
      rise_q  <= rise_d;
      last_q  <= last_d;
    end
  end

  assign evt_valid_o = valid_q;
  assign evt_id_o    = id_q;
  assign evt_rise_o  = rise_q;

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

- Watches NUM_CH asynchronous-to-nothing, already-synchronous level inputs and detects per-channel rising and/or falling edges.
- Each detected edge is latched as a pending event.
- Pending events are serialized onto a single valid/ready event port with round-robin fairness.
- It sits between the board-level edge detectors' input lines and the single event consumer (interrupt/log logic), sharing that consumer among channels.

## Interface
Parameters:
- NUM_CH, default 4, number of input channels (2..16).
- ID_W, derived localparam = $clog2(NUM_CH), channel id width.

Ports:
- clk  input  1  clock.
- reset  input  1  reset: reset, synchronous, active-high; clock clk.
- a_i  input  NUM_CH  level inputs, one bit per channel, synchronous to clk.
- mode_i  input  2*NUM_CH  per-channel edge mode; bits [2c+1:2c] for channel c: 00 off, 01 rising, 10 falling, 11 both.
- evt_valid_o  output  1  event available.
- evt_ready_i  input  1  consumer accepts event.
- evt_id_o  output  ID_W  channel of the presented event.
- evt_rise_o  output  1  1 = rising edge, 0 = falling edge.
- overflow_o  output  NUM_CH  sticky per-channel overflow flags.
- clr_ovf_i  input  1  clears all overflow flags.

## Operation
- **Edge detection.** Per channel, prev[c] registers a_i[c] every cycle.
  - rise = a_i & ~prev; fall = ~a_i & prev.
  - A qualified edge is one enabled by mode_i in the same cycle.
  - During reset, prev loads a_i, so there is no spurious edge on reset release.
- **Pending.** A qualified edge sets pending[c] and stores its type in ptype[c].
- **Overflow.** A qualified edge while pending[c] is already set and channel c is not being loaded this cycle:
  - the new edge is dropped, and the oldest event is kept;
  - overflow[c] is set.
- **Output register.** Holds evt_id_o, evt_rise_o and evt_valid_o. It loads when evt_valid_o=0 or when evt_valid_o&evt_ready_i (the "load slot").
- **Load slot behaviour.** In a load slot:
  - If any pending bit is set, select the winner by round-robin, starting at last_grant+1 with wraparound.
  - Copy the winner's id and ptype to the output, clear pending[winner], set last_grant=winner, and drive valid=1.
  - If no pending bit is set, valid goes to 0.
- **Throughput.** One event per cycle when evt_ready_i is held high.
- **Same-channel collision.** A qualified edge on the winner channel in its own load cycle re-sets pending with the new type. No overflow is flagged.
- **Handshake stability.** While evt_valid_o=1 and evt_ready_i=0, evt_id_o and evt_rise_o are held stable.
- **Mode changes.** Changing mode_i never clears pending events. Mode 00 only suppresses new detection.
- **Overflow clear.** clr_ovf_i clears all overflow bits. If a set and a clear hit the same bit in the same cycle, the set wins.

## Timing
- **Reset values.** On reset:
  - evt_valid_o=0, evt_id_o=0, evt_rise_o=0, overflow_o=0;
  - pending=0, last_grant=NUM_CH-1, so channel 0 has first priority.
- **Reset mid-operation.** Discards all pending events and any presented event. The next cycle after reset deassertion starts clean.
- **Latency.** If a_i[c] changes before posedge k, with prev still holding the old value:
  - pending[c] is set at posedge k;
  - with the output idle, evt_valid_o rises at posedge k+1.
- **Simultaneous edges.** Edges on several channels in one cycle are all latched. They are presented in round-robin order in consecutive load slots.
- **Ready behaviour.** evt_ready_i has no combinational path to any output. evt_ready_i may be high while evt_valid_o=0; no transfer occurs.

## Structure
- **Package edge_evt_pkg:**
  - typedef enum logic [1:0] edge_mode_e {EM_OFF, EM_RISE, EM_FALL, EM_BOTH};
  - function rr_pick(pending, last) returning the winner index.
- **Sub-module edge_evt_chan** (one instance per channel):
  - contains the prev register, mode qualification, pending, ptype and overflow flops;
  - inputs are a_i bit, mode, load-this-channel and clr_ovf;
  - outputs are pending, ptype and overflow.
- **Top module:** a generate loop of edge_evt_chan, the round-robin select, and the output register.

## Test plan
- **Basic rise/fall.** Reset with a_i=0, mode all 11, ready=1. Drive a_i[2] 0→1, then 0 three cycles later. Required: two events, id=2 rise=1 then id=2 rise=0, each evt_valid_o one cycle after pending is set.
- **Round-robin under stall.** mode all 01, ready=0. Raise a_i[3:0] together. Hold ready=0 for 5 cycles, then ready=1. Required: id 0 is held stable throughout the stall, then ids 0,1,2,3 are presented on consecutive cycles.
- **Fairness rotation.** With last_grant=1, pend channels 0 and 3 simultaneously. Required: id 3 is presented before id 0.
- **Overflow and clear.** ready=0, channel 1 mode 11. Toggle a_i[1] twice. Required:
  - a single event with rise=1;
  - overflow_o=4'b0010;
  - clr_ovf_i clears the flag, except when asserted in the same cycle as a new overflow, where the flag stays set.
- **Mode filter and reset.** Channel 0 mode 10. Rising edge → no event; falling edge → id=0 rise=0. Assert reset while an event is valid and others are pending. Required: all outputs are 0 next cycle, and no event appears after reset release with a_i held at 1.
